// File: rtl/fifo_wptr_full_pkg.sv
// Shared pointer helpers for the asynchronous FIFO pointer controllers.
package fifo_wptr_full_pkg;

  // Widest pointer the helpers handle; callers cast in and out of this width.
  localparam int unsigned PTR_MAX_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each bit is the XOR of itself and all higher Gray bits.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < int'(PTR_MAX_W); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Full compare target: the read Gray pointer with its top two bits inverted.
  // w is the pointer width (AW+1).
  function automatic logic [PTR_MAX_W-1:0] full_target(input logic [PTR_MAX_W-1:0] g,
                                                       input int unsigned w);
    return g ^ (PTR_MAX_W'(3) << (w - 2));
  endfunction

endpackage : fifo_wptr_full_pkg

// File: rtl/fifo_wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter for a W-bit pointer.
module fifo_wptr_full_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Binary bit k is the parity of Gray bits W-1 down to k.
  for (genvar k = 0; k < int'(W); k++) begin : g_bit
    assign o_bin[k] = ^(i_gray >> k);
  end

endmodule : fifo_wptr_full_gray2bin

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full flags, fill level and overflow of the async FIFO.
module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int unsigned depth     = 1024,
  parameter int unsigned af_margin = 2,
  localparam int unsigned AW       = $clog2(depth),
  localparam int unsigned PW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [PW-1:0] rgray_sync,
  output logic          wr_fire,
  output logic [AW-1:0] waddr,
  output logic [PW-1:0] wgray,
  output logic          full,
  output logic          almost_full,
  output logic [PW-1:0] wcount,
  output logic          overflow
);

  localparam logic [PW-1:0] AF_THRESH = PW'(depth - af_margin);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic [PW-1:0] r_wcount;
  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;

  logic          w_wr_fire;
  logic [PW-1:0] w_wbin_n;
  logic [PW-1:0] w_wgray_n;
  logic [PW-1:0] w_full_tgt;
  logic [PW-1:0] w_rbin_s;
  logic [PW-1:0] w_fill_n;

  // Read pointer back to binary for the fill-level arithmetic.
  fifo_wptr_full_gray2bin #(
    .W (PW)
  ) u_gray2bin (
    .i_gray (rgray_sync),
    .o_bin  (w_rbin_s)
  );

  // Next-pointer and flag terms, all computed from the post-write pointer.
  assign w_wr_fire  = wr_en & ~r_full;
  assign w_wbin_n   = r_wbin + PW'(w_wr_fire);
  assign w_wgray_n  = PW'(bin2gray(PTR_MAX_W'(w_wbin_n)));
  assign w_full_tgt = PW'(full_target(PTR_MAX_W'(rgray_sync), PW));
  assign w_fill_n   = w_wbin_n - w_rbin_s;

  // Pointer, flag and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wbin        <= '0;
      r_wgray       <= '0;
      r_wcount      <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wbin        <= w_wbin_n;
      r_wgray       <= w_wgray_n;
      r_wcount      <= w_fill_n;
      r_full        <= (w_wgray_n == w_full_tgt);
      r_almost_full <= (w_fill_n >= AF_THRESH);
      r_overflow    <= r_overflow | (wr_en & r_full);
    end
  end

  assign wr_fire     = w_wr_fire;
  assign waddr       = r_wbin[AW-1:0];
  assign wgray       = r_wgray;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign wcount      = r_wcount;
  assign overflow    = r_overflow;

endmodule : fifo_wptr_full
